// File: rtl/date_pkg.sv
// Shared widths, FSM states and calendar constants for the date-setting controller.
package date_pkg;

  localparam int unsigned YearW  = 12;
  localparam int unsigned MonthW = 4;
  localparam int unsigned DayW   = 5;

  localparam logic [YearW-1:0] YearMax = 12'd4095;

  localparam logic [MonthW-1:0] MonJan = 4'd1;
  localparam logic [MonthW-1:0] MonFeb = 4'd2;
  localparam logic [MonthW-1:0] MonMar = 4'd3;
  localparam logic [MonthW-1:0] MonApr = 4'd4;
  localparam logic [MonthW-1:0] MonMay = 4'd5;
  localparam logic [MonthW-1:0] MonJun = 4'd6;
  localparam logic [MonthW-1:0] MonJul = 4'd7;
  localparam logic [MonthW-1:0] MonAug = 4'd8;
  localparam logic [MonthW-1:0] MonSep = 4'd9;
  localparam logic [MonthW-1:0] MonOct = 4'd10;
  localparam logic [MonthW-1:0] MonNov = 4'd11;
  localparam logic [MonthW-1:0] MonDec = 4'd12;

  localparam logic [DayW-1:0] DaysLong  = 5'd31;
  localparam logic [DayW-1:0] DaysShort = 5'd30;
  localparam logic [DayW-1:0] DaysFeb   = 5'd28;

  typedef enum logic [2:0] {
    StIdle,
    StSetYear,
    StSetMonth,
    StSetDay,
    StCommit
  } state_e;

endpackage

// File: rtl/date_max_day.sv
// Month to days-in-month lookup; invalid months return 0. Leap years are not modelled.
module date_max_day
  import date_pkg::*;
(
  input  logic [MonthW-1:0] i_month,
  output logic [DayW-1:0]   o_max_day
);

  always_comb begin
    o_max_day = '0;
    case (i_month)
      MonJan, MonMar, MonMay, MonJul, MonAug, MonOct, MonDec: o_max_day = DaysLong;
      MonApr, MonJun, MonSep, MonNov:                         o_max_day = DaysShort;
      MonFeb:                                                 o_max_day = DaysFeb;
      default:                                                o_max_day = '0;
    endcase
  end

endmodule

// File: rtl/date_set_ctrl.sv
// Button-driven date editor: walks year/month/day fields, then strobes the edit buffer
// into the date counter. Idle edits are abandoned after TIMEOUT_CYC cycles.
module date_set_ctrl
  import date_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_mode,
  input  logic              btn_inc,
  input  logic              btn_dec,
  input  logic              en_day_in,
  input  logic [YearW-1:0]  cur_year,
  input  logic [MonthW-1:0] cur_month,
  input  logic [DayW-1:0]   cur_day,
  output logic              en_day,
  output logic              set_date,
  output logic [20:0]       bin_date,
  output logic [1:0]        edit_field
);

  localparam int unsigned TmoW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

  state_e              r_state, w_state_next;
  logic [YearW-1:0]    r_year, w_year_next;
  logic [MonthW-1:0]   r_month, w_month_next, w_month_step;
  logic [DayW-1:0]     r_day, w_day_next;
  logic [TmoW-1:0]     r_tmo, w_tmo_next;
  logic [DayW-1:0]     w_max_cur, w_max_new;
  logic                w_btn_any, w_inc, w_dec;

  assign w_btn_any = btn_mode | btn_inc | btn_dec;
  // Mode wins over inc/dec; inc and dec together cancel.
  assign w_inc     = btn_inc & ~btn_dec & ~btn_mode;
  assign w_dec     = btn_dec & ~btn_inc & ~btn_mode;

  date_max_day u_max_cur (
    .i_month  (r_month),
    .o_max_day(w_max_cur)
  );

  // Looks up the month the step is about to produce, so the day clamps in the same cycle.
  date_max_day u_max_new (
    .i_month  (w_month_step),
    .o_max_day(w_max_new)
  );

  always_comb begin
    w_month_step = r_month;
    if (r_month == '0 || r_month > MonDec) begin
      w_month_step = MonJan;
    end else if (w_inc) begin
      w_month_step = (r_month == MonDec) ? MonJan : r_month + 4'd1;
    end else begin
      w_month_step = (r_month == MonJan) ? MonDec : r_month - 4'd1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_year_next  = r_year;
    w_month_next = r_month;
    w_day_next   = r_day;
    w_tmo_next   = '0;
    unique case (r_state)
      StIdle: begin
        if (btn_mode) begin
          w_year_next  = cur_year;
          w_month_next = cur_month;
          w_day_next   = cur_day;
          w_state_next = StSetYear;
        end
      end
      StSetYear, StSetMonth, StSetDay: begin
        if (w_btn_any) begin
          w_tmo_next = '0;
        end else if (r_tmo == TmoLast) begin
          w_state_next = StIdle;
        end else begin
          w_tmo_next = r_tmo + 1'b1;
        end
        if (btn_mode) begin
          unique case (r_state)
            StSetYear:  w_state_next = StSetMonth;
            StSetMonth: w_state_next = StSetDay;
            default:    w_state_next = StCommit;
          endcase
        end else if (w_inc || w_dec) begin
          unique case (r_state)
            StSetYear: begin
              if (w_inc) w_year_next = (r_year == YearMax) ? YearW'(1) : r_year + YearW'(1);
              else       w_year_next = (r_year <= YearW'(1)) ? YearMax : r_year - YearW'(1);
            end
            StSetMonth: begin
              w_month_next = w_month_step;
              w_day_next   = (r_day > w_max_new) ? w_max_new : r_day;
            end
            default: begin
              if (w_inc) w_day_next = (r_day >= w_max_cur) ? DayW'(1) : r_day + DayW'(1);
              else if (r_day <= DayW'(1) || r_day > w_max_cur) w_day_next = w_max_cur;
              else w_day_next = r_day - DayW'(1);
            end
          endcase
        end
      end
      StCommit: w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_year  <= '0;
      r_month <= '0;
      r_day   <= '0;
      r_tmo   <= '0;
    end else begin
      r_state <= w_state_next;
      r_year  <= w_year_next;
      r_month <= w_month_next;
      r_day   <= w_day_next;
      r_tmo   <= w_tmo_next;
    end
  end

  always_comb begin
    edit_field = 2'd0;
    unique case (r_state)
      StSetYear:  edit_field = 2'd1;
      StSetMonth: edit_field = 2'd2;
      StSetDay:   edit_field = 2'd3;
      default:    edit_field = 2'd0;
    endcase
  end

  assign bin_date = {r_year, r_month, r_day};
  assign set_date = (r_state == StCommit);
  assign en_day   = en_day_in & ~rst & (r_state == StIdle);

endmodule

// File: tb/tb_date_set_ctrl.sv
// Directed vector bench for date_set_ctrl: a cycle table plus hand sequences for wraps,
// commit, timeout and reset-mid-edit.
module tb_date_set_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_mode, btn_inc, btn_dec, en_day_in;
  logic [11:0] cur_year;
  logic [3:0]  cur_month;
  logic [4:0]  cur_day;
  logic        en_day, set_date;
  logic [20:0] bin_date;
  logic [1:0]  edit_field;

  int n_vec = 0;
  int n_err = 0;
  int n_set = 0;
  int base;

  always #5 clk = ~clk;

  date_set_ctrl #(.TIMEOUT_CYC(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .btn_dec   (btn_dec),
    .en_day_in (en_day_in),
    .cur_year  (cur_year),
    .cur_month (cur_month),
    .cur_day   (cur_day),
    .en_day    (en_day),
    .set_date  (set_date),
    .bin_date  (bin_date),
    .edit_field(edit_field)
  );

  always @(negedge clk) if (set_date) n_set <= n_set + 1;

  typedef struct {
    logic m, i, d, e;
    logic [11:0] y;
    logic [3:0]  mo;
    logic [4:0]  dy;
    logic [1:0]  ef;
    logic        sd, ed;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic m, i, d, e, input logic [11:0] y, input logic [3:0] mo,
                     input logic [4:0] dy, input logic [1:0] ef, input logic sd, ed);
    vec_t v;
    v.m = m; v.i = i; v.d = d; v.e = e;
    v.y = y; v.mo = mo; v.dy = dy; v.ef = ef; v.sd = sd; v.ed = ed;
    vecs.push_back(v);
  endtask

  function automatic logic [24:0] ex(input logic [11:0] y, input logic [3:0] mo,
                                     input logic [4:0] dy, input logic [1:0] ef,
                                     input logic sd, ed);
    return {y, mo, dy, ef, sd, ed};
  endfunction

  task automatic chk(input string name, input logic [24:0] exp);
    logic [24:0] act;
    act = {bin_date, edit_field, set_date, en_day};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got y=%0d m=%0d d=%0d field=%0d set=%b en=%b, want y=%0d m=%0d d=%0d field=%0d set=%b en=%b",
               name, act[24:13], act[12:9], act[8:4], act[3:2], act[1], act[0],
               exp[24:13], exp[12:9], exp[8:4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic m, i, d, e);
    btn_mode = m; btn_inc = i; btn_dec = d; en_day_in = e;
    @(posedge clk);
    #1;
  endtask

  task automatic abort_edit();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  task automatic set_cur(input logic [11:0] y, input logic [3:0] mo, input logic [4:0] dy);
    cur_year = y; cur_month = mo; cur_day = dy;
  endtask

  initial begin
    rst = 1'b1;
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0; en_day_in = 1'b1;
    set_cur(12'd2024, 4'd1, 5'd31);

    //    m  i  d  e   year   mo  day ef set en
    add(0, 0, 0, 1, 0,    0,  0,  0, 0, 1);  // idle tick passes
    add(0, 1, 0, 0, 0,    0,  0,  0, 0, 0);  // inc ignored in idle
    add(1, 0, 0, 1, 2024, 1,  31, 1, 0, 0);  // load, tick dropped
    add(0, 1, 0, 0, 2025, 1,  31, 1, 0, 0);
    add(0, 0, 1, 0, 2024, 1,  31, 1, 0, 0);
    add(0, 1, 1, 0, 2024, 1,  31, 1, 0, 0);  // inc+dec cancel
    add(1, 1, 0, 0, 2024, 1,  31, 2, 0, 0);  // mode wins
    add(0, 1, 0, 1, 2024, 2,  28, 2, 0, 0);  // clamp to Feb
    add(0, 0, 1, 0, 2024, 1,  28, 2, 0, 0);
    add(0, 0, 1, 0, 2024, 12, 28, 2, 0, 0);
    add(0, 1, 0, 0, 2024, 1,  28, 2, 0, 0);
    add(1, 0, 0, 0, 2024, 1,  28, 3, 0, 0);
    add(0, 0, 1, 0, 2024, 1,  27, 3, 0, 0);
    add(0, 1, 0, 0, 2024, 1,  28, 3, 0, 0);
    add(0, 1, 0, 0, 2024, 1,  29, 3, 0, 0);
    add(0, 1, 0, 0, 2024, 1,  30, 3, 0, 0);
    add(0, 1, 0, 0, 2024, 1,  31, 3, 0, 0);
    add(0, 1, 0, 0, 2024, 1,  1,  3, 0, 0);
    add(0, 0, 1, 0, 2024, 1,  31, 3, 0, 0);
    add(1, 0, 0, 0, 2024, 1,  31, 0, 1, 0);  // commit strobe
    add(0, 0, 0, 0, 2024, 1,  31, 0, 0, 0);
    add(0, 0, 0, 1, 2024, 1,  31, 0, 0, 1);  // buffer held in idle

    #12;
    chk("reset", ex(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[k]) begin
      cyc(vecs[k].m, vecs[k].i, vecs[k].d, vecs[k].e);
      chk($sformatf("vec%0d", k),
          ex(vecs[k].y, vecs[k].mo, vecs[k].dy, vecs[k].ef, vecs[k].sd, vecs[k].ed));
    end

    abort_edit();
    set_cur(12'd4095, 4'd6, 5'd15);
    cyc(1, 0, 0, 0); chk("year_load", ex(4095, 6, 15, 1, 0, 0));
    cyc(0, 1, 0, 0); chk("year_wrap_up", ex(1, 6, 15, 1, 0, 0));
    cyc(0, 0, 1, 0); chk("year_wrap_dn", ex(4095, 6, 15, 1, 0, 0));

    abort_edit();
    set_cur(12'd0, 4'd6, 5'd15);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0); chk("year0_dec", ex(4095, 6, 15, 1, 0, 0));

    abort_edit();
    set_cur(12'd2000, 4'd0, 5'd5);
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0); chk("mon0_inc", ex(2000, 1, 5, 2, 0, 0));

    abort_edit();
    set_cur(12'd2000, 4'd13, 5'd31);
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0); chk("mon13_dec", ex(2000, 1, 31, 2, 0, 0));

    abort_edit();
    set_cur(12'd2024, 4'd3, 5'd31);
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0); chk("clamp30", ex(2024, 4, 30, 2, 0, 0));

    abort_edit();
    set_cur(12'd2023, 4'd7, 5'd4);
    base = n_set;
    cyc(1, 0, 0, 0); cyc(0, 1, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    chk("pre_commit", ex(2024, 7, 4, 3, 0, 0));
    cyc(1, 0, 0, 0); chk("commit", ex(2024, 7, 4, 0, 1, 0));
    cyc(0, 0, 0, 0); chk("post_commit", ex(2024, 7, 4, 0, 0, 0));
    cyc(0, 0, 0, 0);
    chk_int("set_pulses", n_set - base, 1);

    set_cur(12'd2024, 4'd5, 5'd10);
    base = n_set;
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    chk("tmo_entry", ex(2024, 5, 10, 3, 0, 0));
    repeat (15) cyc(0, 0, 0, 0);
    chk("tmo_15", ex(2024, 5, 10, 3, 0, 0));
    cyc(0, 0, 0, 0);
    chk("tmo_16", ex(2024, 5, 10, 0, 0, 0));
    chk_int("tmo_no_set", n_set - base, 0);

    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    chk("rst_entry", ex(2024, 5, 10, 3, 0, 0));
    base = n_set;
    en_day_in = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_mid", ex(0, 0, 0, 0, 0, 0));
    cyc(1, 0, 0, 1); chk("rst_hold", ex(0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    cyc(0, 0, 0, 1); chk("rst_release", ex(0, 0, 0, 0, 0, 1));
    cyc(0, 0, 0, 0);
    chk_int("rst_no_set", n_set - base, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
